// File: rtl/data_mem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
// FSM encoding, legal byte-enable patterns and counter width.
package data_mem_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;
  localparam logic [3:0] BE_H0 = 4'b0011;
  localparam logic [3:0] BE_H1 = 4'b1100;
  localparam logic [3:0] BE_W  = 4'b1111;

  localparam int CNT_W = 4;

  // Only naturally aligned byte, halfword and word lanes are legal.
  function automatic logic be_legal(input logic [3:0] be);
    return (be == BE_B0) || (be == BE_B1) ||
           (be == BE_B2) || (be == BE_B3) ||
           (be == BE_H0) || (be == BE_H1) ||
           (be == BE_W);
  endfunction

endpackage

// File: rtl/data_mem_resp_array.sv
// Data RAM: DEPTH_WORDS x 32, four byte lanes, sync write, comb read.
// Ports: i_clk, i_we (per-lane), i_addr (word index), i_wdata, o_rdata.
module data_mem_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter              INIT_FILE   = "",
  parameter int unsigned AW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          i_clk,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we[i]) begin
        r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: captures an LSU request, waits, accesses RAM.
// Ports: clk_i, arst_i, data_req/we/be/addr/wdata in; rdata/ready/err/busy out.
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk_i,
  input  logic        arst_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_ready_o,
  output logic        data_err_o,
  output logic        data_busy_o
);

  localparam int unsigned AW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  // One past the last valid byte; 33 bits so the top never wraps.
  localparam logic [32:0] LIMIT =
    {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  state_t r_state;
  state_t w_next;

  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic [3:0]       r_be;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  logic             r_err;

  logic          w_err;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_lane_we;
  logic [31:0]   w_mem_rdata;

  assign w_err = (r_addr[1:0] != 2'b00)
              || (r_addr < BASE_ADDR)
              || ({1'b0, r_addr} >= LIMIT)
              || !be_legal(r_be);

  assign w_idx = AW'((r_addr - BASE_ADDR) >> 2);

  assign w_lane_we =
    (r_state == ST_ACCESS && !w_err && r_we) ? r_be : 4'b0000;

  data_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE),
    .AW          (AW)
  ) u_array (
    .i_clk   (clk_i),
    .i_we    (w_lane_we),
    .i_addr  (w_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (data_req_i) begin
          w_next = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt <= 1) begin
          w_next = ST_ACCESS;
        end
      end
      ST_ACCESS: w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Busy rises combinationally with the request so the PC stalls
  // in the same cycle the request is taken.
  always_comb begin
    data_ready_o = (r_state == ST_RESP);
    data_err_o   = (r_state == ST_RESP) && r_err;
    data_busy_o  = (r_state != ST_IDLE) || data_req_i;
    data_rdata_o = r_rdata;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_be    <= 4'b0000;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (data_req_i) begin
            r_we    <= data_we_i;
            r_be    <= data_be_i;
            r_addr  <= data_addr_i;
            r_wdata <= data_wdata_i;
            r_cnt   <= WAIT_LD;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 1'b1;
        end
        ST_ACCESS: begin
          r_err <= w_err;
          if (w_err) begin
            r_rdata <= '0;
          end else if (!r_we) begin
            r_rdata <= w_mem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp (WAIT_CYCLES=1 and 0 instances).
// Directed steps plus random traffic against a word-level memory model.
module tb_data_mem_resp;

  localparam int WA = 1;

  logic        clk = 1'b0;
  logic        arst;
  logic        req_a, req_b;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;

  logic [31:0] rdata_a, rdata_b;
  logic        rdy_a, err_a, busy_a;
  logic        rdy_b, err_b, busy_b;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mem_m [int];
  logic [31:0] rdata_m;

  always #5 clk = ~clk;

  data_mem_resp #(
    .DEPTH_WORDS (256),
    .BASE_ADDR   (32'h0),
    .WAIT_CYCLES (WA),
    .INIT_FILE   ("")
  ) u_a (
    .clk_i        (clk),
    .arst_i       (arst),
    .data_req_i   (req_a),
    .data_we_i    (we),
    .data_be_i    (be),
    .data_addr_i  (addr),
    .data_wdata_i (wdata),
    .data_rdata_o (rdata_a),
    .data_ready_o (rdy_a),
    .data_err_o   (err_a),
    .data_busy_o  (busy_a)
  );

  data_mem_resp #(
    .DEPTH_WORDS (256),
    .BASE_ADDR   (32'h0),
    .WAIT_CYCLES (0),
    .INIT_FILE   ("")
  ) u_b (
    .clk_i        (clk),
    .arst_i       (arst),
    .data_req_i   (req_b),
    .data_we_i    (we),
    .data_be_i    (be),
    .data_addr_i  (addr),
    .data_wdata_i (wdata),
    .data_rdata_o (rdata_b),
    .data_ready_o (rdy_b),
    .data_err_o   (err_b),
    .data_busy_o  (busy_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_err(input logic [3:0] b,
                                   input logic [31:0] a);
    logic ok_be;
    ok_be = b inside {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                      4'b0011, 4'b1100, 4'b1111};
    return (a % 4 != 0) || (a >= 32'h400) || !ok_be;
  endfunction

  // One transaction on instance A; optional junk requests are pulsed
  // while it is in WAIT and in RESP.
  task automatic txn(input logic w, input logic [3:0] b,
                     input logic [31:0] a, input logic [31:0] d,
                     input bit pulse = 1'b0);
    logic        e;
    logic [31:0] old_rd, m;
    int          wi;
    e  = exp_err(b, a);
    wi = int'(a >> 2);
    @(negedge clk);
    chk("idle_busy", busy_a, 0);
    chk("idle_rdy", rdy_a, 0);
    req_a = 1'b1; we = w; be = b; addr = a; wdata = d;
    @(posedge clk);
    #1 req_a = 1'b0;
    old_rd = rdata_m;
    if (e) begin
      rdata_m = 32'h0;
    end else if (w) begin
      m = mem_m.exists(wi) ? mem_m[wi] : 32'h0;
      for (int i = 0; i < 4; i++)
        if (b[i]) m[8*i +: 8] = d[8*i +: 8];
      mem_m[wi] = m;
    end else begin
      rdata_m = mem_m[wi];
    end
    for (int k = 1; k <= WA + 2; k++) begin
      @(negedge clk);
      if (pulse && (k == 1 || k == 3)) begin
        req_a = 1'b1; we = 1'b1; be = 4'hF;
        addr = 32'h30; wdata = 32'h1111_1111;
      end
      if (pulse && k == 2) req_a = 1'b0;
      chk("rdy", rdy_a, (k == WA + 2));
      chk("busy", busy_a, 1);
      chk("err", err_a, (k == WA + 2) ? e : 1'b0);
      chk("rdata", rdata_a, (k == WA + 2) ? rdata_m : old_rd);
    end
    if (pulse) begin
      @(posedge clk);
      #1 req_a = 1'b0;
    end
  endtask

  initial begin
    logic [3:0]  legal [7];
    logic [31:0] a, d;
    logic [3:0]  b;
    int          r;
    legal = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
              4'b0011, 4'b1100, 4'b1111};
    arst = 1'b1; req_a = 0; req_b = 0;
    we = 0; be = 0; addr = 0; wdata = 0;
    rdata_m = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_rdata", rdata_a, 0);
    chk("rst_rdy", rdy_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_b_rdy", rdy_b, 0);
    chk("rst_b_rdata", rdata_b, 0);
    arst = 1'b0;

    // Word write / read
    txn(1, 4'hF, 32'h10, 32'hDEAD_BEEF);
    txn(0, 4'hF, 32'h10, 32'h0);
    // Byte and halfword merges
    txn(1, 4'b0100, 32'h10, 32'h5A5A_5A5A);
    txn(1, 4'hF, 32'h14, 32'h0);
    txn(1, 4'b1100, 32'h14, 32'h1234_1234);
    txn(0, 4'hF, 32'h10, 32'h0);
    txn(0, 4'hF, 32'h14, 32'h0);
    // Errors
    txn(0, 4'hF, 32'h12, 32'h0);
    txn(0, 4'hF, 32'h400, 32'h0);
    txn(0, 4'hF, 32'h3FC, 32'h0);
    txn(1, 4'b0101, 32'h10, 32'hFFFF_FFFF);
    txn(1, 4'b0000, 32'h10, 32'hFFFF_FFFF);
    txn(0, 4'hF, 32'h10, 32'h0);
    // Requests outside IDLE are ignored
    txn(1, 4'hF, 32'h30, 32'h2222_2222);
    txn(1, 4'hF, 32'h34, 32'hABCD_0123, 1'b1);
    txn(0, 4'hF, 32'h30, 32'h0);

    // Reset during WAIT discards a pending write
    txn(1, 4'hF, 32'h20, 32'h7654_3210);
    txn(0, 4'hF, 32'h20, 32'h0);
    @(negedge clk);
    req_a = 1'b1; we = 1'b1; be = 4'hF;
    addr = 32'h20; wdata = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 req_a = 1'b0;
    @(negedge clk);
    chk("wait_busy", busy_a, 1);
    chk("wait_rdy", rdy_a, 0);
    #1 arst = 1'b1;
    #1;
    chk("arst_busy", busy_a, 0);
    chk("arst_rdy", rdy_a, 0);
    chk("arst_err", err_a, 0);
    chk("arst_rdata", rdata_a, 0);
    @(negedge clk);
    arst = 1'b0;
    rdata_m = 32'h0;
    txn(0, 4'hF, 32'h20, 32'h0);

    // WAIT_CYCLES=0: request held high, ready every third cycle
    @(negedge clk);
    req_b = 1'b1; we = 1'b1; be = 4'hF;
    addr = 32'h40; wdata = 32'hCAFE_F00D;
    #1 chk("b_cap_busy", busy_b, 1);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) we = 1'b0;
      chk("b_rdy", rdy_b, (k % 3 == 2));
      chk("b_busy", busy_b, 1);
      if (k == 5 || k == 8) begin
        chk("b_rdata", rdata_b, 32'hCAFE_F00D);
        chk("b_err", err_b, 0);
      end
    end
    req_b = 1'b0;
    @(negedge clk);
    chk("b_idle_busy", busy_b, 0);
    chk("b_idle_rdy", rdy_b, 0);

    // Random traffic on a 16-word region plus illegal requests
    for (int i = 0; i < 16; i++)
      txn(1, 4'hF, 32'h80 + 32'(4 * i), $urandom);
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      a = 32'h80 + 32'(4 * $urandom_range(0, 15));
      if (r == 0) a = a + 32'($urandom_range(1, 3));
      if (r == 1) a = 32'h400 + 32'(4 * $urandom_range(0, 3));
      if (r == 2) a = 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) != 0)
        b = legal[$urandom_range(0, 6)];
      else
        b = 4'($urandom_range(0, 15));
      d = $urandom;
      txn(1'($urandom_range(0, 1)), b, a, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
